spi_master_fifo: RTL and testbench
==================================

# spi_master_fifo

Parametrised SPI master with transmit and receive FIFOs. It is the successor to the fixed 8-bit sender/receiver pair and adds configurable word width, FIFO depth, SCLK divider, all four CPOL/CPHA modes, chip-select framing and an overflow flag. It sits between a host register interface (WRITE/READ strobes) and the off-chip SPI pins.

## Interface
- DATA_W, 8: bits per SPI word (≥2).
- DEPTH, 4: entries per FIFO (power of two, ≥2).
- DIV, 2: CLK cycles per SCLK half-period (≥1).

- CLK  in  1  system clock; all logic is rising-edge.
- CLR  in  1  asynchronous, active-low reset.
- DATA_IN  in  DATA_W  word to enqueue in the TX FIFO.
- WRITE  in  1  1-cycle strobe; pushes DATA_IN.
- READ  in  1  1-cycle strobe; pops the RX FIFO head into DATA_OUT.
- DATA_OUT  out  DATA_W  last popped RX word (registered).
- TE  in  1  transmit enable; frames start only while high.
- CPOL  in  1  SCLK idle level.
- CPHA  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- SCLK  out  1  serial clock.
- MOSI  out  1  serial data out, MSB first.
- MISO  in  1  serial data in, MSB first.
- CS_N  out  1  active-low frame select.
- TX_FULL, TX_EMPTY, RX_FULL, RX_EMPTY  out  1  FIFO status.
- BUSY  out  1  high from frame start until CS_N rises.
- RX_OVF  out  1  sticky; set when a received word is dropped.

## Operation
- Reset values: DATA_OUT=0, SCLK=0, MOSI=0, CS_N=1, TX_EMPTY=1, RX_EMPTY=1, TX_FULL=0, RX_FULL=0, BUSY=0, RX_OVF=0. Both FIFOs are emptied. Reset mid-frame aborts the frame immediately.
- WRITE while TX_FULL is ignored: word lost, no flag. READ while RX_EMPTY is ignored and DATA_OUT holds.
- WRITE coincident with a TX pop, and READ coincident with an RX push, are both legal. Occupancy changes by the net amount and nothing is lost.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full and empty are decided by the MSB compare.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: SCLK follows CPOL. When TE=1 and !TX_EMPTY, pop the TX head into the shift register, latch CPOL/CPHA, drive CS_N=0 and BUSY=1, then go to SHIFT.
  - SHIFT: SCLK toggles every DIV cycles, 2·DATA_W edges in total. CPHA=0: MOSI = MSB from CS_N fall; sample MISO on odd edges; shift on even edges. CPHA=1: shift on odd edges (first MSB out on edge 1); sample on even edges. After the last edge, go to GAP.
  - GAP: CS_N=1, BUSY=0. Push the received word to the RX FIFO. If RX_FULL, drop the word and set RX_OVF. Hold for DIV cycles, then return to IDLE.
- Dropping TE mid-frame has no effect; the current frame completes. CPOL/CPHA changes take effect only at the next frame start.
- RX_OVF clears only on reset.

## Timing
- t0 is the cycle in which CS_N falls: one CLK after TE=1 && !TX_EMPTY is seen in IDLE.
- SCLK edge k (k = 1..2·DATA_W) occurs at t0 + k·DIV.
- At t0 + (2·DATA_W+1)·DIV, CS_N rises and the RX word becomes visible (RX_EMPTY falls, or RX_OVF rises). For defaults that is t0+34.
- The next CS_N fall is no earlier than DIV+1 cycles after CS_N rises.
- TX_FULL/TX_EMPTY update on the cycle after WRITE or pop. DATA_OUT updates on the cycle after READ.

## Test plan
- Reset: assert CLR=0 mid-frame -> every output at its reset value within the same cycle, CS_N=1, both FIFOs empty.
- Loopback (MISO=MOSI), mode 0, defaults: write 8'h43 and 8'h5F, raise TE -> two frames, each CS_N low for 34 cycles. Then READ, READ -> DATA_OUT=8'h43, then 8'h5F, RX_EMPTY=1.
- All four CPOL/CPHA modes with word 8'hA5: SCLK idles at CPOL, MOSI changes only on the shift edges, loopback returns 8'hA5.
- TX full: with TE=0, write DEPTH+1 words -> TX_FULL=1 after the 4th, 5th word dropped. Enable TE -> exactly 4 frames.
- RX overflow: 5 loopback frames with no READ -> RX_FULL after the 4th, RX_OVF=1 after the 5th. READ returns the first 4 words in order.
- Parameters DATA_W=16, DEPTH=8, DIV=1: word 16'hBEEF loops back, CS_N low for 33 cycles. TE dropped at edge 5 -> frame still completes.

Source files
------------

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, configurable word width, FIFO depth and SCLK divider.
// Supports all four CPOL/CPHA modes; one word per chip-select frame.
module spi_master_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DIV    = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              WRITE,
  input  logic              READ,
  output logic [DATA_W-1:0] DATA_OUT,
  input  logic              TE,
  input  logic              CPOL,
  input  logic              CPHA,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_N,
  output logic              TX_FULL,
  output logic              TX_EMPTY,
  output logic              RX_FULL,
  output logic              RX_EMPTY,
  output logic              BUSY,
  output logic              RX_OVF
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DIV + 1);
  localparam int unsigned EW = $clog2(2 * DATA_W + 1);
  localparam logic [CW-1:0] DivLast  = CW'(DIV - 1);
  localparam logic [EW-1:0] EdgeLast = EW'(2 * DATA_W);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q;
  logic [CW-1:0]     div_cnt_q;
  logic [EW-1:0]     edge_cnt_q;
  logic              cpha_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW:0]       tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;

  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              div_done, frame_end;
  logic [DATA_W-1:0] tx_head;

  assign TX_EMPTY = (tx_wptr_q == tx_rptr_q);
  assign TX_FULL  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign RX_EMPTY = (rx_wptr_q == rx_rptr_q);
  assign RX_FULL  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

  assign tx_head   = tx_mem[tx_rptr_q[AW-1:0]];
  assign div_done  = (div_cnt_q == DivLast);
  // One extra half-period after the last SCLK edge before CS_N rises.
  assign frame_end = (state_q == StShift) && div_done && (edge_cnt_q == EdgeLast);

  assign tx_push = WRITE && !TX_FULL;
  assign tx_pop  = (state_q == StIdle) && TE && !TX_EMPTY;
  assign rx_push = frame_end && !RX_FULL;
  assign rx_pop  = READ && !RX_EMPTY;

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= DATA_IN;
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      DATA_OUT  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop) begin
        rx_rptr_q <= rx_rptr_q + 1'b1;
        DATA_OUT  <= rx_mem[rx_rptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= StIdle;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      cpha_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      CS_N       <= 1'b1;
      BUSY       <= 1'b0;
      RX_OVF     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          SCLK <= CPOL;
          if (tx_pop) begin
            cpha_q     <= CPHA;
            CS_N       <= 1'b0;
            BUSY       <= 1'b1;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            state_q    <= StShift;
            // CPHA=0 presents the MSB with CS_N; CPHA=1 waits for the first edge.
            if (!CPHA) begin
              MOSI    <= tx_head[DATA_W-1];
              tx_sh_q <= tx_head << 1;
            end else begin
              tx_sh_q <= tx_head;
            end
          end
        end

        StShift: begin
          if (div_done) begin
            div_cnt_q <= '0;
            if (edge_cnt_q == EdgeLast) begin
              state_q <= StGap;
              CS_N    <= 1'b1;
              BUSY    <= 1'b0;
              if (RX_FULL) RX_OVF <= 1'b1;
            end else begin
              SCLK       <= ~SCLK;
              edge_cnt_q <= edge_cnt_q + 1'b1;
              // edge_cnt_q[0]==0 marks an odd edge (1, 3, ...).
              if (edge_cnt_q[0] == cpha_q) begin
                rx_sh_q <= {rx_sh_q[DATA_W-2:0], MISO};
              end else begin
                MOSI    <= tx_sh_q[DATA_W-1];
                tx_sh_q <= tx_sh_q << 1;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end

        StGap: begin
          if (div_done) begin
            div_cnt_q <= '0;
            state_q   <= StIdle;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Scoreboard bench for spi_master_fifo: default instance in loopback plus a 16-bit, DIV=1 instance.
module tb_spi_master_fifo;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int DV = 2;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  always #5 CLK = ~CLK;

  // Default instance
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic write = 1'b0, read = 1'b0, te = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic sclk, mosi, miso, cs_n, tx_full, tx_empty, rx_full, rx_empty, busy, rx_ovf;
  assign miso = mosi;

  spi_master_fifo #(.DATA_W(DW), .DEPTH(DP), .DIV(DV)) dut (
    .CLK(CLK), .CLR(CLR), .DATA_IN(data_in), .WRITE(write), .READ(read),
    .DATA_OUT(data_out), .TE(te), .CPOL(cpol), .CPHA(cpha), .SCLK(sclk),
    .MOSI(mosi), .MISO(miso), .CS_N(cs_n), .TX_FULL(tx_full), .TX_EMPTY(tx_empty),
    .RX_FULL(rx_full), .RX_EMPTY(rx_empty), .BUSY(busy), .RX_OVF(rx_ovf)
  );

  // Wide instance: DATA_W=16, DEPTH=8, DIV=1
  logic [15:0] w_data_in = '0;
  logic [15:0] w_data_out;
  logic w_write = 1'b0, w_read = 1'b0, w_te = 1'b0;
  logic w_sclk, w_mosi, w_miso, w_cs_n, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_busy, w_rx_ovf;
  assign w_miso = w_mosi;

  spi_master_fifo #(.DATA_W(16), .DEPTH(8), .DIV(1)) dut_w (
    .CLK(CLK), .CLR(CLR), .DATA_IN(w_data_in), .WRITE(w_write), .READ(w_read),
    .DATA_OUT(w_data_out), .TE(w_te), .CPOL(1'b0), .CPHA(1'b0), .SCLK(w_sclk),
    .MOSI(w_mosi), .MISO(w_miso), .CS_N(w_cs_n), .TX_FULL(w_tx_full),
    .TX_EMPTY(w_tx_empty), .RX_FULL(w_rx_full), .RX_EMPTY(w_rx_empty), .BUSY(w_busy),
    .RX_OVF(w_rx_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: words accepted into TX, words expected in RX, expected overflow flag.
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] inflight = '0;
  logic [DW-1:0] last_exp = '0;
  logic          exp_ovf  = 1'b0;

  int  frames_started = 0, frames_done = 0;
  int  low_len = 0, last_low_len = 0, first_edge_off = 0, edge_num = 0, shift_viol = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

  // Frame monitor for the default instance.
  initial begin
    forever begin
      @(negedge CLK);
      if (!CLR) begin
        prev_cs  = 1'b1;
        edge_num = 0;
        low_len  = 0;
      end else begin
        if (!cs_n && prev_cs) begin
          frames_started++;
          low_len  = 1;
          edge_num = 0;
          if (tx_q.size() > 0) inflight = tx_q.pop_front();
        end else if (!cs_n) begin
          logic chg, is_shift;
          low_len++;
          chg = (sclk != prev_sclk);
          if (chg) begin
            edge_num++;
            if (edge_num == 1) first_edge_off = low_len - 1;
          end
          is_shift = chg && (cpha ? (edge_num % 2 == 1) : (edge_num % 2 == 0));
          if (mosi != prev_mosi && !is_shift) shift_viol++;
        end else if (!prev_cs) begin
          last_low_len = low_len;
          frames_done++;
          if (rx_q.size() < DP) rx_q.push_back(inflight);
          else exp_ovf = 1'b1;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_mosi = mosi;
      end
    end
  end

  task automatic write_word(input logic [DW-1:0] w);
    if (tx_q.size() < DP) tx_q.push_back(w);
    @(posedge CLK); #1;
    data_in = w;
    write   = 1'b1;
    @(posedge CLK); #1;
    write   = 1'b0;
  endtask

  task automatic read_check(input string tag);
    if (rx_q.size() > 0) last_exp = rx_q.pop_front();
    @(posedge CLK); #1;
    read = 1'b1;
    @(posedge CLK); #1;
    read = 1'b0;
    check(tag, 32'(data_out), 32'(last_exp));
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (frames_done < target && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("frames_done", frames_done, target);
    repeat (DV + 3) @(negedge CLK);
  endtask

  initial begin
    int base;
    int n;
    int len;
    int edges;
    logic ps;
    logic seen_low;

    // Reset values
    #12;
    check("rst_cs_n", 32'(cs_n), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_flags", {tx_empty, rx_empty, tx_full, rx_full, busy, rx_ovf}, 6'b110000);
    check("rst_data_out", 32'(data_out), 0);
    @(negedge CLK);
    CLR = 1'b1;
    repeat (2) @(negedge CLK);

    // Mode 0 loopback, two frames
    write_word(8'h43);
    write_word(8'h5F);
    check("tx_empty_after_wr", 32'(tx_empty), 0);
    te = 1'b1;
    wait_done(2);
    te = 1'b0;
    check("frames_started", frames_started, 2);
    check("cs_low_len", last_low_len, 34);
    check("first_edge_off", first_edge_off, DV);
    check("rx_empty_after_2", 32'(rx_empty), 0);
    read_check("loop_rd0");
    read_check("loop_rd1");
    check("rx_empty_after_rd", 32'(rx_empty), 1);
    read_check("rd_empty_hold");

    // All four modes with 8'hA5
    for (int m = 0; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      shift_viol = 0;
      repeat (3) @(negedge CLK);
      check("sclk_idle_pre", 32'(sclk), 32'(cpol));
      base = frames_done;
      write_word(8'hA5);
      te = 1'b1;
      wait_done(base + 1);
      te = 1'b0;
      check("mosi_shift_edges", shift_viol, 0);
      check("sclk_idle_post", 32'(sclk), 32'(cpol));
      check("mode_low_len", last_low_len, 34);
      read_check("mode_rd");
    end
    cpol = 1'b0;
    cpha = 1'b0;

    // TX full: DEPTH+1 writes with TE low
    base = frames_done;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    check("tx_full_3", 32'(tx_full), 0);
    write_word(8'h44);
    check("tx_full_4", 32'(tx_full), 1);
    write_word(8'h55);
    check("tx_full_5", 32'(tx_full), 1);
    te = 1'b1;
    wait_done(base + 4);
    repeat (40) @(negedge CLK);
    te = 1'b0;
    check("txfull_frames", frames_done - base, 4);
    check("tx_empty_drain", 32'(tx_empty), 1);
    for (int i = 0; i < 4; i++) read_check("txfull_rd");
    check("rx_empty_txfull", 32'(rx_empty), 1);

    // RX overflow: five frames, no READ until the end
    base = frames_done;
    write_word(8'hC1);
    write_word(8'hC2);
    write_word(8'hC3);
    write_word(8'hC4);
    te = 1'b1;
    n = 0;
    while (!tx_empty && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check("tx_drained", 32'(tx_empty), 1);
    write_word(8'hC5);
    wait_done(base + 4);
    check("rx_full_4", 32'(rx_full), 1);
    check("rx_ovf_4", 32'(rx_ovf), 32'(exp_ovf));
    wait_done(base + 5);
    te = 1'b0;
    check("rx_ovf_5", 32'(rx_ovf), 32'(exp_ovf));
    check("rx_ovf_set", 32'(rx_ovf), 1);
    for (int i = 0; i < 4; i++) read_check("ovf_rd");
    check("rx_empty_ovf", 32'(rx_empty), 1);
    check("rx_ovf_sticky", 32'(rx_ovf), 1);

    // Wide instance: 16'hBEEF, TE dropped at edge 5
    @(posedge CLK); #1;
    w_data_in = 16'hBEEF;
    w_write   = 1'b1;
    @(posedge CLK); #1;
    w_write   = 1'b0;
    w_te      = 1'b1;
    len = 0;
    edges = 0;
    ps = w_sclk;
    seen_low = 1'b0;
    n = 0;
    while (!(seen_low && w_cs_n) && n < 500) begin
      @(negedge CLK);
      n++;
      if (!w_cs_n) begin
        seen_low = 1'b1;
        len++;
        if (w_sclk != ps) edges++;
        if (edges == 5) w_te = 1'b0;
      end
      ps = w_sclk;
    end
    w_te = 1'b0;
    check("w_cs_low_len", len, 33);
    check("w_edges", edges, 32);
    check("w_rx_empty", 32'(w_rx_empty), 0);
    @(posedge CLK); #1;
    w_read = 1'b1;
    @(posedge CLK); #1;
    w_read = 1'b0;
    check("w_loopback", 32'(w_data_out), 32'h0000BEEF);

    // Reset mid-frame
    write_word(8'h3C);
    te = 1'b1;
    n = 0;
    while (cs_n && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("frame_started_rst", 32'(cs_n), 0);
    repeat (7) @(posedge CLK);
    #2;
    CLR = 1'b0;
    te  = 1'b0;
    #1;
    tx_q.delete();
    rx_q.delete();
    exp_ovf  = 1'b0;
    last_exp = '0;
    check("rst_mid_cs_n", 32'(cs_n), 1);
    check("rst_mid_sclk_mosi", {sclk, mosi}, 2'b00);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_flags", {tx_empty, rx_empty, tx_full, rx_full, rx_ovf}, 5'b11000);
    check("rst_mid_data_out", 32'(data_out), 0);
    @(negedge CLK);
    CLR = 1'b1;
    repeat (60) @(negedge CLK);
    check("post_rst_idle", {cs_n, busy, rx_empty}, 3'b101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
